cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter.sv | 171 +++++++++++++++++
 tb/tb_cdb_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding register per functional unit, a single registered CDB broadcast per cycle.
// Define CDB_ARBITER_RR_EN for round-robin arbitration; the default build uses fixed priority (lowest index wins).
module cdb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TAG_WIDTH  = 6,
    parameter int NUM_SRC    = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                i_flush,
    input  logic [NUM_SRC-1:0]                  i_fu_valid,
    output logic [NUM_SRC-1:0]                  o_fu_ready,
    input  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]  i_fu_data,
    input  logic [NUM_SRC-1:0][ADDR_WIDTH-1:0]  i_fu_addr,
    input  logic [NUM_SRC-1:0]                  i_fu_redirect,
    input  logic [NUM_SRC-1:0][TAG_WIDTH-1:0]   i_fu_tag,
    output logic                                o_cdb_en,
    output logic [DATA_WIDTH-1:0]               o_cdb_data,
    output logic [ADDR_WIDTH-1:0]               o_cdb_addr,
    output logic                                o_cdb_redirect,
    output logic [TAG_WIDTH-1:0]                o_cdb_tag
);

    localparam int IDX_W = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0]    hv_q, hv_d;
    logic [DATA_WIDTH-1:0] holdData_q [NUM_SRC];
    logic [DATA_WIDTH-1:0] holdData_d [NUM_SRC];
    logic [ADDR_WIDTH-1:0] holdAddr_q [NUM_SRC];
    logic [ADDR_WIDTH-1:0] holdAddr_d [NUM_SRC];
    logic [TAG_WIDTH-1:0]  holdTag_q  [NUM_SRC];
    logic [TAG_WIDTH-1:0]  holdTag_d  [NUM_SRC];
    logic [NUM_SRC-1:0]    holdRedir_q, holdRedir_d;

    logic                  cdbEn_q, cdbEn_d;
    logic [DATA_WIDTH-1:0] cdbData_q, cdbData_d;
    logic [ADDR_WIDTH-1:0] cdbAddr_q, cdbAddr_d;
    logic                  cdbRedir_q, cdbRedir_d;
    logic [TAG_WIDTH-1:0]  cdbTag_q, cdbTag_d;

    logic [NUM_SRC-1:0]    gnt;
    logic [IDX_W-1:0]      gntIdx;
    logic                  gntAny;
    logic [NUM_SRC-1:0]    xfer;

    // A source may refill in the same cycle its held result is granted, so the stage never bubbles.
    assign o_fu_ready = {NUM_SRC{~rst & ~i_flush}} & (~hv_q | gnt);
    assign xfer       = i_fu_valid & o_fu_ready;

`ifdef CDB_ARBITER_RR_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W:0]   candSum;
    logic [IDX_W-1:0] cand;

    // Walk the holding registers starting at the pointer, wrapping modulo NUM_SRC.
    always_comb begin
        gnt     = '0;
        gntIdx  = '0;
        gntAny  = 1'b0;
        candSum = '0;
        cand    = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            candSum = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (candSum >= (IDX_W+1)'(NUM_SRC)) begin
                candSum = candSum - (IDX_W+1)'(NUM_SRC);
            end
            cand = candSum[IDX_W-1:0];
            if (!gntAny && hv_q[cand]) begin
                gnt[cand] = 1'b1;
                gntIdx    = cand;
                gntAny    = 1'b1;
            end
        end
    end
`else
    always_comb begin
        gnt    = '0;
        gntIdx = '0;
        gntAny = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!gntAny && hv_q[k]) begin
                gnt[k] = 1'b1;
                gntIdx = IDX_W'(k);
                gntAny = 1'b1;
            end
        end
    end
`endif

    // Flush wins over grants and transfers; reset is applied in the register process.
    always_comb begin
        hv_d        = hv_q;
        holdData_d  = holdData_q;
        holdAddr_d  = holdAddr_q;
        holdTag_d   = holdTag_q;
        holdRedir_d = holdRedir_q;
        cdbEn_d     = 1'b0;
        cdbData_d   = cdbData_q;
        cdbAddr_d   = cdbAddr_q;
        cdbRedir_d  = cdbRedir_q;
        cdbTag_d    = cdbTag_q;
`ifdef CDB_ARBITER_RR_EN
        ptr_d       = ptr_q;
`endif
        if (i_flush) begin
            hv_d = '0;
        end else begin
            if (gntAny) begin
                cdbEn_d    = 1'b1;
                cdbData_d  = holdData_q[gntIdx];
                cdbAddr_d  = holdAddr_q[gntIdx];
                cdbRedir_d = holdRedir_q[gntIdx];
                cdbTag_d   = holdTag_q[gntIdx];
`ifdef CDB_ARBITER_RR_EN
                ptr_d      = (gntIdx == IDX_W'(NUM_SRC - 1)) ? '0 : gntIdx + 1'b1;
`endif
            end
            for (int i = 0; i < NUM_SRC; i++) begin
                if (xfer[i]) begin
                    hv_d[i]        = 1'b1;
                    holdData_d[i]  = i_fu_data[i];
                    holdAddr_d[i]  = i_fu_addr[i];
                    holdRedir_d[i] = i_fu_redirect[i];
                    holdTag_d[i]   = i_fu_tag[i];
                end else if (gnt[i]) begin
                    hv_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hv_q       <= '0;
            cdbEn_q    <= 1'b0;
            cdbData_q  <= '0;
            cdbAddr_q  <= '0;
            cdbRedir_q <= 1'b0;
            cdbTag_q   <= '0;
`ifdef CDB_ARBITER_RR_EN
            ptr_q      <= '0;
`endif
        end else begin
            hv_q       <= hv_d;
            cdbEn_q    <= cdbEn_d;
            cdbData_q  <= cdbData_d;
            cdbAddr_q  <= cdbAddr_d;
            cdbRedir_q <= cdbRedir_d;
            cdbTag_q   <= cdbTag_d;
`ifdef CDB_ARBITER_RR_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

    // Payload storage is qualified by hv_q, so it needs no reset.
    always_ff @(posedge clk) begin
        holdData_q  <= holdData_d;
        holdAddr_q  <= holdAddr_d;
        holdTag_q   <= holdTag_d;
        holdRedir_q <= holdRedir_d;
    end

    assign o_cdb_en       = cdbEn_q;
    assign o_cdb_data     = cdbData_q;
    assign o_cdb_addr     = cdbAddr_q;
    assign o_cdb_redirect = cdbRedir_q;
    assign o_cdb_tag      = cdbTag_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus randomized traffic against a per-source pending-result model.
// Follows CDB_ARBITER_RR_EN the same way the design does.
module tb_cdb_arbiter;

    localparam int NS = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TW = 6;

    logic                   clk;
    logic                   rst;
    logic                   flush;
    logic [NS-1:0]          valid;
    logic [NS-1:0]          ready;
    logic [NS-1:0][DW-1:0]  data;
    logic [NS-1:0][AW-1:0]  addr;
    logic [NS-1:0]          redirect;
    logic [NS-1:0][TW-1:0]  tag;
    logic                   cdbEn;
    logic [DW-1:0]          cdbData;
    logic [AW-1:0]          cdbAddr;
    logic                   cdbRedirect;
    logic [TW-1:0]          cdbTag;

    cdb_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .NUM_SRC(NS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_flush        (flush),
        .i_fu_valid     (valid),
        .o_fu_ready     (ready),
        .i_fu_data      (data),
        .i_fu_addr      (addr),
        .i_fu_redirect  (redirect),
        .i_fu_tag       (tag),
        .o_cdb_en       (cdbEn),
        .o_cdb_data     (cdbData),
        .o_cdb_addr     (cdbAddr),
        .o_cdb_redirect (cdbRedirect),
        .o_cdb_tag      (cdbTag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic          v;
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        logic          r;
        logic [TW-1:0] t;
    } entry_t;

    int checks   = 0;
    int failures = 0;

    // What each functional unit is currently offering
    logic [NS-1:0] offValid;
    logic [DW-1:0] offData  [NS];
    logic [AW-1:0] offAddr  [NS];
    logic          offRedir [NS];
    logic [TW-1:0] offTag   [NS];

    // Reference: one pending result per source and the last broadcast
    entry_t        mHold [NS];
    entry_t        mOut;
    logic          mEn;
    int            mPtr;
    logic [NS-1:0] mXfer;

    task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", name, obs, exp, $time);
        end
    endtask

    function automatic int pickWinner();
        int s;
        for (int k = 0; k < NS; k++) begin
`ifdef CDB_ARBITER_RR_EN
            s = (mPtr + k) % NS;
`else
            s = k;
`endif
            if (mHold[s].v) return s;
        end
        return -1;
    endfunction

    function automatic logic [NS-1:0] expReady(input int w);
        logic [NS-1:0] r;
        for (int s = 0; s < NS; s++) begin
            r[s] = !rst && !flush && (!mHold[s].v || s == w);
        end
        return r;
    endfunction

    task automatic modelStep();
        int w;
        w     = pickWinner();
        mXfer = offValid & expReady(w);
        if (rst) begin
            for (int s = 0; s < NS; s++) mHold[s].v = 1'b0;
            mEn  = 1'b0;
            mOut = '0;
            mPtr = 0;
        end else if (flush) begin
            for (int s = 0; s < NS; s++) mHold[s].v = 1'b0;
            mEn = 1'b0;
        end else begin
            mEn = (w >= 0);
            if (w >= 0) begin
                mOut = mHold[w];
                mPtr = (w + 1) % NS;
                mHold[w].v = 1'b0;
            end
            for (int s = 0; s < NS; s++) begin
                if (mXfer[s]) mHold[s] = {1'b1, offData[s], offAddr[s], offRedir[s], offTag[s]};
            end
        end
    endtask

    // One clock cycle: drive just after the rising edge, compare on the falling edge.
    task automatic applyStimulus(input logic r, input logic f);
        int w;
        @(posedge clk);
        #1;
        rst   = r;
        flush = f;
        valid = offValid;
        for (int s = 0; s < NS; s++) begin
            data[s]     = offData[s];
            addr[s]     = offAddr[s];
            redirect[s] = offRedir[s];
            tag[s]      = offTag[s];
        end
        @(negedge clk);
        w = pickWinner();
        checkOutput("ready",        64'(ready),       64'(expReady(w)));
        checkOutput("cdb_en",       64'(cdbEn),       64'(mEn));
        checkOutput("cdb_data",     64'(cdbData),     64'(mOut.d));
        checkOutput("cdb_addr",     64'(cdbAddr),     64'(mOut.a));
        checkOutput("cdb_redirect", 64'(cdbRedirect), 64'(mOut.r));
        checkOutput("cdb_tag",      64'(cdbTag),      64'(mOut.t));
        modelStep();
    endtask

    task automatic setOffer(input int s, input logic v, input logic [TW-1:0] t);
        offValid[s] = v;
        offTag[s]   = t;
        offData[s]  = $urandom;
        offAddr[s]  = $urandom;
        offRedir[s] = 1'($urandom_range(0, 1));
    endtask

    task automatic resetDut();
        offValid = '0;
        applyStimulus(1'b1, 1'b0);
    endtask

    initial begin
        rst      = 1'b1;
        flush    = 1'b0;
        valid    = '0;
        data     = '0;
        addr     = '0;
        redirect = '0;
        tag      = '0;
        offValid = '0;
        for (int s = 0; s < NS; s++) begin
            offData[s] = '0; offAddr[s] = '0; offRedir[s] = 1'b0; offTag[s] = '0;
            mHold[s]   = '0;
        end
        mOut  = '0;
        mEn   = 1'b0;
        mPtr  = 0;
        mXfer = '0;

        // Single result from src1 appears two cycles later, for exactly one cycle
        resetDut();
        checkOutput("reset_en", 64'(cdbEn), 64'd0);
        checkOutput("reset_ready", 64'(ready), 64'd0);
        setOffer(1, 1'b1, TW'(5));
        offData[1] = 32'hDEADBEEF;
        applyStimulus(1'b0, 1'b0);
        offValid = '0;
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("single_en_c2", 64'(cdbEn), 64'd1);
        checkOutput("single_tag_c2", 64'(cdbTag), 64'd5);
        checkOutput("single_data_c2", 64'(cdbData), 64'hDEADBEEF);
        applyStimulus(1'b0, 1'b0);
        checkOutput("single_en_c3", 64'(cdbEn), 64'd0);

        // All sources saturating the bus
        resetDut();
        for (int s = 0; s < NS; s++) setOffer(s, 1'b1, TW'(s));
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1'b0, 1'b0);
            if (k >= 1) begin
`ifdef CDB_ARBITER_RR_EN
                checkOutput("sat_ready_rr", 64'(ready), 64'(1 << ((k - 1) % NS)));
                if (k >= 2) checkOutput("sat_tag_rr", 64'(cdbTag), 64'((k - 2) % NS));
`else
                checkOutput("sat_ready_fixed", 64'(ready), 64'd1);
                if (k >= 2) checkOutput("sat_tag_fixed", 64'(cdbTag), 64'd0);
`endif
            end
        end

        // Flush discards a pending tag 9 from src2
        resetDut();
        setOffer(2, 1'b1, TW'(9));
        applyStimulus(1'b0, 1'b0);
        offValid = '0;
        applyStimulus(1'b0, 1'b1);
        checkOutput("flush_ready", 64'(ready), 64'd0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("flush_ready_after", 64'(ready), 64'hF);
        checkOutput("flush_en_c2", 64'(cdbEn), 64'd0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("flush_en_c3", 64'(cdbEn), 64'd0);

        // src3 streams tags 10,11,12 back to back
        resetDut();
        for (int k = 0; k < 5; k++) begin
            if (k < 3) setOffer(3, 1'b1, TW'(10 + k));
            else offValid[3] = 1'b0;
            applyStimulus(1'b0, 1'b0);
            if (k < 3) checkOutput("stream_ready3", 64'(ready[3]), 64'd1);
            if (k >= 2) begin
                checkOutput("stream_en", 64'(cdbEn), 64'd1);
                checkOutput("stream_tag", 64'(cdbTag), 64'(10 + k - 2));
            end
        end

        // Reset in the middle of traffic drops everything pending
        resetDut();
        setOffer(0, 1'b1, TW'(20));
        setOffer(1, 1'b1, TW'(21));
        setOffer(3, 1'b1, TW'(23));
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        offValid = '0;
        applyStimulus(1'b1, 1'b0);
        checkOutput("midrst_en_before", 64'(cdbEn), 64'd1);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput("midrst_en", 64'(cdbEn), 64'd0);
            if (k == 0) begin
                checkOutput("midrst_tag", 64'(cdbTag), 64'd0);
                checkOutput("midrst_data", 64'(cdbData), 64'd0);
                checkOutput("midrst_addr", 64'(cdbAddr), 64'd0);
                checkOutput("midrst_redirect", 64'(cdbRedirect), 64'd0);
            end
        end

        // Randomized traffic with occasional flush and reset
        resetDut();
        for (int n = 0; n < 3000; n++) begin
            for (int s = 0; s < NS; s++) begin
                if (!offValid[s] || mXfer[s]) begin
                    setOffer(s, 1'($urandom_range(0, 3) != 0), TW'($urandom));
                end
            end
            applyStimulus(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 29) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
